// File: rtl/knn_pkg.sv
// rtl/knn_pkg.sv - shared KNN constants, widths and control-FSM state encoding
package knn_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        SELECT = 2'd2,
        DONE   = 2'd3
    } knn_state_e;

    function automatic int NUM_CLASSES(input int type_w);
        return 1 << type_w;
    endfunction

    function automatic int VOTE_W(input int k);
        return $clog2(k + 1);
    endfunction
endpackage

// File: rtl/knn_vote_table.sv
// rtl/knn_vote_table.sv - per-class vote counters and first-occurrence index register file
module knn_vote_table
    import knn_pkg::*;
#(
    parameter int TYPE_W = 3,
    parameter int K      = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc_en,
    input  logic [TYPE_W-1:0]    inc_cls,
    input  logic [VOTE_W(K)-1:0] inc_pos,
    input  logic [TYPE_W-1:0]    rd_cls,
    output logic [VOTE_W(K)-1:0] rd_votes,
    output logic [VOTE_W(K)-1:0] rd_first
);
    localparam int C  = NUM_CLASSES(TYPE_W);
    localparam int VW = VOTE_W(K);
    // K is never a valid position, so it marks a class not yet seen
    localparam logic [VW-1:0] ABSENT = VW'(K);

    logic [VW-1:0] votes_q [C];
    logic [VW-1:0] votes_d [C];
    logic [VW-1:0] first_q [C];
    logic [VW-1:0] first_d [C];

    always_comb begin
        for (int i = 0; i < C; i++) begin
            votes_d[i] = votes_q[i];
            first_d[i] = first_q[i];
        end
        if (clr) begin
            for (int i = 0; i < C; i++) begin
                votes_d[i] = '0;
                first_d[i] = ABSENT;
            end
        end else if (inc_en) begin
            votes_d[inc_cls] = votes_q[inc_cls] + VW'(1);
            if (first_q[inc_cls] == ABSENT) begin
                first_d[inc_cls] = inc_pos;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < C; i++) begin
                votes_q[i] <= '0;
                first_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < C; i++) begin
                votes_q[i] <= votes_d[i];
                first_q[i] <= first_d[i];
            end
        end
    end

    assign rd_votes = votes_q[rd_cls];
    assign rd_first = first_q[rd_cls];
endmodule

// File: rtl/knn_majority_vote.sv
// rtl/knn_majority_vote.sv - majority vote over the K nearest entries of a sorted distance vector
module knn_majority_vote
    import knn_pkg::*;
#(
    parameter int L      = 4,
    parameter int W      = 16,
    parameter int TYPE_W = 3,
    parameter int K      = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [W*(1<<L)-1:0]      in,
    input  logic [TYPE_W*(1<<L)-1:0] in_type,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [TYPE_W-1:0]        out_type,
    output logic [VOTE_W(K)-1:0]     out_votes,
    output logic [W-1:0]             out_nearest_dist,
    output logic                     drop
);
    localparam int N  = 1 << L;
    localparam int C  = NUM_CLASSES(TYPE_W);
    localparam int VW = VOTE_W(K);
    localparam int CW = TYPE_W + 1;

    if (K < 1 || K > N) begin : g_bad_k
        $error("knn_majority_vote: K must be in 1..N");
    end

    if (K < N) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^{in[W*N-1:W*K], in_type[TYPE_W*N-1:TYPE_W*K]};
    end

    knn_state_e        state_q, state_d;
    logic [VW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     cls_q, cls_d;
    logic [TYPE_W-1:0] best_type_q, best_type_d;
    logic [VW-1:0]     best_votes_q, best_votes_d;
    logic [VW-1:0]     best_first_q, best_first_d;
    logic [W-1:0]      dist_q [K];
    logic [W-1:0]      dist_d [K];
    logic [TYPE_W-1:0] type_q [K];
    logic [TYPE_W-1:0] type_d [K];
    logic              out_valid_q, out_valid_d;
    logic [TYPE_W-1:0] out_type_q, out_type_d;
    logic [VW-1:0]     out_votes_q, out_votes_d;
    logic [W-1:0]      out_dist_q, out_dist_d;
    logic              drop_q, drop_d;

    logic              tbl_clr;
    logic              tbl_inc;
    logic [VW-1:0]     rd_votes;
    logic [VW-1:0]     rd_first;
    logic              better;

    knn_vote_table #(.TYPE_W(TYPE_W), .K(K)) u_table (
        .clk      (clk),
        .rst      (rst),
        .clr      (tbl_clr),
        .inc_en   (tbl_inc),
        .inc_cls  (type_q[idx_q]),
        .inc_pos  (idx_q),
        .rd_cls   (cls_q[TYPE_W-1:0]),
        .rd_votes (rd_votes),
        .rd_first (rd_first)
    );

    // The cycle carrying out_valid is still busy, so a vector then is dropped
    assign in_ready = (state_q == IDLE) && !out_valid_q;

    // Equal counts fall to the earlier first occurrence; first indices never collide
    assign better = (rd_votes > best_votes_q) ||
                    ((rd_votes == best_votes_q) && (rd_votes != '0) && (rd_first < best_first_q));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cls_d        = cls_q;
        best_type_d  = best_type_q;
        best_votes_d = best_votes_q;
        best_first_d = best_first_q;
        out_valid_d  = 1'b0;
        out_type_d   = out_type_q;
        out_votes_d  = out_votes_q;
        out_dist_d   = out_dist_q;
        drop_d       = in_valid && !in_ready;
        tbl_clr      = 1'b0;
        tbl_inc      = 1'b0;
        for (int i = 0; i < K; i++) begin
            dist_d[i] = dist_q[i];
            type_d[i] = type_q[i];
        end
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    for (int i = 0; i < K; i++) begin
                        dist_d[i] = in[W*i +: W];
                        type_d[i] = in_type[TYPE_W*i +: TYPE_W];
                    end
                    tbl_clr = 1'b1;
                    idx_d   = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                tbl_inc = 1'b1;
                if (idx_q == VW'(K - 1)) begin
                    cls_d        = '0;
                    best_type_d  = '0;
                    best_votes_d = '0;
                    best_first_d = VW'(K);
                    state_d      = SELECT;
                end else begin
                    idx_d = idx_q + VW'(1);
                end
            end
            SELECT: begin
                if (better) begin
                    best_type_d  = cls_q[TYPE_W-1:0];
                    best_votes_d = rd_votes;
                    best_first_d = rd_first;
                end
                if (cls_q == CW'(C - 1)) begin
                    state_d = DONE;
                end else begin
                    cls_d = cls_q + CW'(1);
                end
            end
            DONE: begin
                out_valid_d = 1'b1;
                out_type_d  = best_type_q;
                out_votes_d = best_votes_q;
                out_dist_d  = dist_q[best_first_q];
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cls_q        <= '0;
            best_type_q  <= '0;
            best_votes_q <= '0;
            best_first_q <= '0;
            out_valid_q  <= 1'b0;
            out_type_q   <= '0;
            out_votes_q  <= '0;
            out_dist_q   <= '0;
            drop_q       <= 1'b0;
            for (int i = 0; i < K; i++) begin
                dist_q[i] <= '0;
                type_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cls_q        <= cls_d;
            best_type_q  <= best_type_d;
            best_votes_q <= best_votes_d;
            best_first_q <= best_first_d;
            out_valid_q  <= out_valid_d;
            out_type_q   <= out_type_d;
            out_votes_q  <= out_votes_d;
            out_dist_q   <= out_dist_d;
            drop_q       <= drop_d;
            for (int i = 0; i < K; i++) begin
                dist_q[i] <= dist_d[i];
                type_q[i] <= type_d[i];
            end
        end
    end

    assign out_valid        = out_valid_q;
    assign out_type         = out_type_q;
    assign out_votes        = out_votes_q;
    assign out_nearest_dist = out_dist_q;
    assign drop             = drop_q;
endmodule

// File: tb/tb_knn_majority_vote.sv
// tb/tb_knn_majority_vote.sv - bench for knn_majority_vote (K=5 and K=1 builds)
module tb_knn_majority_vote;
    localparam int L = 4;
    localparam int N = 16;
    localparam int W = 16;
    localparam int TW = 3;
    localparam int C = 8;
    localparam int KA = 5;
    localparam int KB = 1;

    typedef struct {
        int t;
        int v;
        int d;
        int cap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            a_in_valid = 1'b0;
    logic [W*N-1:0]  a_in = '0;
    logic [TW*N-1:0] a_in_type = '0;
    logic            a_in_ready, a_out_valid, a_drop;
    logic [TW-1:0]   a_out_type;
    logic [2:0]      a_out_votes;
    logic [W-1:0]    a_out_dist;

    logic            b_in_valid = 1'b0;
    logic [W*N-1:0]  b_in = '0;
    logic [TW*N-1:0] b_in_type = '0;
    logic            b_in_ready, b_out_valid, b_drop;
    logic [TW-1:0]   b_out_type;
    logic [0:0]      b_out_votes;
    logic [W-1:0]    b_out_dist;

    knn_majority_vote #(.L(L), .W(W), .TYPE_W(TW), .K(KA)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in(a_in), .in_type(a_in_type),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_type(a_out_type),
        .out_votes(a_out_votes), .out_nearest_dist(a_out_dist), .drop(a_drop)
    );

    knn_majority_vote #(.L(L), .W(W), .TYPE_W(TW), .K(KB)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in(b_in), .in_type(b_in_type),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_type(b_out_type),
        .out_votes(b_out_votes), .out_nearest_dist(b_out_dist), .drop(b_drop)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   a_drops = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   g_ty[N];
    int   g_ds[N];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Winner: highest count; among equals, the class appearing nearest in the list
    function automatic exp_t model(input int k, input int ty[N], input int ds[N]);
        int   cnt[C];
        int   best;
        bit   found;
        exp_t r;
        for (int c = 0; c < C; c++) cnt[c] = 0;
        for (int i = 0; i < k; i++) cnt[ty[i]]++;
        best = 0;
        for (int c = 0; c < C; c++) if (cnt[c] > best) best = cnt[c];
        found = 1'b0;
        r = '{t: 0, v: 0, d: 0, cap: 0};
        for (int i = 0; i < k; i++) begin
            if (!found && cnt[ty[i]] == best) begin
                r.t = ty[i];
                r.v = best;
                r.d = ds[i];
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (a_drop) a_drops++;
            if (a_out_valid) begin
                if (qa.size() == 0) begin
                    check("a_spurious_valid", a_out_valid, 0);
                end else begin
                    ea = qa.pop_front();
                    check("a_type", a_out_type, ea.t);
                    check("a_votes", a_out_votes, ea.v);
                    check("a_dist", a_out_dist, ea.d);
                    check("a_latency", cyc - ea.cap, KA + C + 1);
                    check("a_ready_in_valid_cycle", a_in_ready, 0);
                end
            end
            if (b_out_valid) begin
                if (qb.size() == 0) begin
                    check("b_spurious_valid", b_out_valid, 0);
                end else begin
                    eb = qb.pop_front();
                    check("b_type", b_out_type, eb.t);
                    check("b_votes", b_out_votes, eb.v);
                    check("b_dist", b_out_dist, eb.d);
                    check("b_latency", cyc - eb.cap, KB + C + 1);
                end
            end
        end
    end

    task automatic mk(input int t0, input int t1, input int t2, input int t3, input int t4,
                      input int d0, input int d1, input int d2, input int d3, input int d4);
        for (int i = 0; i < N; i++) begin
            g_ty[i] = 0;
            g_ds[i] = 1;
        end
        g_ty[0] = t0; g_ty[1] = t1; g_ty[2] = t2; g_ty[3] = t3; g_ty[4] = t4;
        g_ds[0] = d0; g_ds[1] = d1; g_ds[2] = d2; g_ds[3] = d3; g_ds[4] = d4;
    endtask

    task automatic send(input bit sel_b, input int k, input int ty[N], input int ds[N]);
        exp_t            e;
        logic [W*N-1:0]  vin;
        logic [TW*N-1:0] vty;
        @(negedge clk);
        e = model(k, ty, ds);
        e.cap = cyc + 1;
        for (int i = 0; i < N; i++) begin
            vin[W*i +: W]   = W'(ds[i]);
            vty[TW*i +: TW] = TW'(ty[i]);
        end
        if (sel_b) begin
            b_in = vin; b_in_type = vty; b_in_valid = 1'b1;
            check("b_ready_at_send", b_in_ready, 1);
            qb.push_back(e);
        end else begin
            a_in = vin; a_in_type = vty; a_in_valid = 1'b1;
            check("a_ready_at_send", a_in_ready, 1);
            qa.push_back(e);
        end
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", qa.size() + qb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int d0;
        exp_t m;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        exp_t m;
        repeat (2) @(negedge clk);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_type", a_out_type, 0);
        check("rst_out_votes", a_out_votes, 0);
        check("rst_out_dist", a_out_dist, 0);
        check("rst_drop", a_drop, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_a_ready", a_in_ready, 1);
        check("rst_b_ready", b_in_ready, 1);

        // 1: tie between classes 1 and 2, class 2 nearer
        mk(2, 1, 2, 1, 3, 10, 20, 30, 40, 50);
        m = model(KA, g_ty, g_ds);
        check("model_t1_type", m.t, 2);
        check("model_t1_dist", m.d, 10);
        send(0, KA, g_ty, g_ds);
        wait_drain();
        check("t1_type", a_out_type, 2);
        check("t1_votes", a_out_votes, 2);
        check("t1_dist", a_out_dist, 10);

        // 2: clear majority
        mk(4, 6, 6, 6, 4, 5, 7, 9, 11, 13);
        send(0, KA, g_ty, g_ds);
        wait_drain();
        check("t2_type", a_out_type, 6);
        check("t2_votes", a_out_votes, 3);
        check("t2_dist", a_out_dist, 7);

        // 3: unanimous; entries 5..15 are class 0 and must be ignored
        mk(7, 7, 7, 7, 7, 3, 8, 12, 20, 25);
        send(0, KA, g_ty, g_ds);
        wait_drain();
        check("t3_type", a_out_type, 7);
        check("t3_votes", a_out_votes, 5);
        check("t3_dist", a_out_dist, 3);

        // all distinct: class 0 wins on proximity
        mk(0, 1, 2, 3, 4, 11, 22, 33, 44, 55);
        send(0, KA, g_ty, g_ds);
        wait_drain();
        check("tu_type", a_out_type, 0);
        check("tu_votes", a_out_votes, 1);
        check("tu_dist", a_out_dist, 11);

        // 4: a second pulse while busy is dropped
        d0 = a_drops;
        mk(3, 5, 3, 5, 5, 2, 4, 6, 8, 10);
        send(0, KA, g_ty, g_ds);
        repeat (2) @(negedge clk);
        a_in_type = {(TW*N){1'b1}};
        a_in_valid = 1'b1;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        wait_drain();
        repeat (20) @(negedge clk);
        check("t4_drop_count", a_drops - d0, 1);
        check("t4_type", a_out_type, 5);
        check("t4_votes", a_out_votes, 3);
        check("t4_dist", a_out_dist, 4);

        // 5: reset during SELECT aborts the vector
        mk(1, 2, 3, 4, 5, 9, 19, 29, 39, 49);
        send(0, KA, g_ty, g_ds);
        repeat (KA + 3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_valid", a_out_valid, 0);
        check("t5_rst_type", a_out_type, 0);
        check("t5_rst_votes", a_out_votes, 0);
        check("t5_rst_dist", a_out_dist, 0);
        check("t5_rst_drop", a_drop, 0);
        qa.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_ready_after_rst", a_in_ready, 1);
        mk(0, 0, 1, 1, 1, 100, 90, 80, 70, 60);
        send(0, KA, g_ty, g_ds);
        wait_drain();
        repeat (5) @(negedge clk);
        check("t5_type", a_out_type, 1);
        check("t5_votes", a_out_votes, 3);
        check("t5_dist", a_out_dist, 80);

        // 6: K=1 build, only entry 0 counts
        mk(5, 0, 0, 0, 0, 99, 1, 1, 1, 1);
        for (int i = 1; i < N; i++) begin
            g_ty[i] = int'($urandom_range(0, 7));
            g_ds[i] = int'($urandom_range(0, 65535));
        end
        send(1, KB, g_ty, g_ds);
        wait_drain();
        check("t6_type", b_out_type, 5);
        check("t6_votes", b_out_votes, 1);
        check("t6_dist", b_out_dist, 99);

        mk(0, 7, 7, 7, 7, 1234, 2, 3, 4, 5);
        send(1, KB, g_ty, g_ds);
        wait_drain();
        check("t6b_type", b_out_type, 0);
        check("t6b_dist", b_out_dist, 1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
